// File: rtl/frame_demap_pkg.sv
// Shared frame geometry and state encoding for the line-side mapper and demapper.
package frame_demap_pkg;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_LOF_THRESH = 2;
    localparam int NUM_ROWS       = 4;
    localparam int ROW_LEN        = 1041;
    localparam int OH_COLS        = 16;
    localparam int PAD_COL        = ROW_LEN - 1;
    localparam int ROW_W          = 2;
    localparam int COL_W          = 11;

    typedef logic [ROW_W-1:0] row_t;
    typedef logic [COL_W-1:0] col_t;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_e;

    localparam row_t LAST_ROW   = row_t'(NUM_ROWS - 1);
    localparam col_t PAD_COL_C  = col_t'(PAD_COL);
    localparam col_t PYLD_FIRST = col_t'(OH_COLS);
endpackage

// File: rtl/frame_demap_pos_cnt.sv
// Row/col position tracker: registers the position of the last accepted beat and
// decodes the position of the beat currently on the line.
module frame_pos_cnt
    import frame_demap_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    input  logic             zero_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             is_sof_pos_o,
    output logic             is_oh_o,
    output logic             is_pyld_o,
    output logic             is_pad_o,
    output logic             is_frame_end_o
);
    row_t row_q, row_d, inc_row, beat_row;
    col_t col_q, col_d, inc_col, beat_col;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        inc_row = row_q;
        inc_col = col_q + 1'b1;
        if (col_q == PAD_COL_C) begin
            inc_col = '0;
            inc_row = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end
        // A loaded beat (SOF or hunting) is by definition row 0, col 0.
        beat_row = zero_i ? '0 : inc_row;
        beat_col = zero_i ? '0 : inc_col;
        row_d    = adv_i ? beat_row : row_q;
        col_d    = adv_i ? beat_col : col_q;
    end

    assign is_sof_pos_o   = (inc_row == '0) && (inc_col == '0);
    assign is_oh_o        = beat_col < PYLD_FIRST;
    assign is_pyld_o      = (beat_col >= PYLD_FIRST) && (beat_col < PAD_COL_C);
    assign is_pad_o       = beat_col == PAD_COL_C;
    assign is_frame_end_o = is_pad_o && (beat_row == LAST_ROW);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;
endmodule

// File: rtl/frame_demap.sv
// Receive frame demapper: locks to SOF, strips overhead/pad, forwards payload, flags drops.
// Define FRAME_DEMAP_OH_EXTRACT_EN to expose overhead bytes on o_oh_data/o_oh_valid.
module frame_demap
    import frame_demap_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LOF_THRESH = DEF_LOF_THRESH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_line_data,
    input  logic              i_line_valid,
    input  logic              i_line_sof,
    input  logic              i_pyld_fifo_ready,
    output logic [DATA_W-1:0] o_pyld_data,
    output logic              o_pyld_valid,
    output logic [ROW_W-1:0]  o_row_cnt,
    output logic [COL_W-1:0]  o_col_cnt,
    output logic              o_in_frame,
    output logic              o_frame_err,
    output logic              o_retrans_req
`ifdef FRAME_DEMAP_OH_EXTRACT_EN
    ,
    output logic [DATA_W-1:0] o_oh_data,
    output logic              o_oh_valid
`endif
);
    localparam int MISS_W = $clog2(LOF_THRESH + 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOF_THRESH);

    state_e            state_q, state_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              drop_q, drop_d;
    logic              pyld_valid_q, pyld_valid_d;
    logic [DATA_W-1:0] pyld_data_q;
    logic              frame_err_q, frame_err_d;
    logic              retrans_q, retrans_d;
    logic              is_sof_pos, is_oh, is_pyld, is_pad, is_frame_end;
`ifdef FRAME_DEMAP_OH_EXTRACT_EN
    logic              oh_valid_q, oh_valid_d;
    logic [DATA_W-1:0] oh_data_q;
`endif

    frame_pos_cnt u_pos (
        .clk_i          (i_clk),
        .rst_i          (i_rst),
        .adv_i          (i_line_valid && ((state_q == SYNC) || i_line_sof)),
        .zero_i         (i_line_sof || (state_q == HUNT)),
        .row_o          (o_row_cnt),
        .col_o          (o_col_cnt),
        .is_sof_pos_o   (is_sof_pos),
        .is_oh_o        (is_oh),
        .is_pyld_o      (is_pyld),
        .is_pad_o       (is_pad),
        .is_frame_end_o (is_frame_end)
    );

    always_comb begin
        state_d      = state_q;
        miss_d       = miss_q;
        drop_d       = drop_q;
        pyld_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        retrans_d    = 1'b0;
`ifdef FRAME_DEMAP_OH_EXTRACT_EN
        oh_valid_d   = 1'b0;
`endif
        case (state_q)
            HUNT: begin
                if (i_line_valid && i_line_sof) begin
                    state_d = SYNC;
                    miss_d  = '0;
                    drop_d  = 1'b0;
                end
            end
            SYNC: begin
                if (i_line_valid) begin
                    case (1'b1)
                        is_oh: begin
`ifdef FRAME_DEMAP_OH_EXTRACT_EN
                            oh_valid_d = 1'b1;
`endif
                        end
                        is_pyld: begin
                            if (i_pyld_fifo_ready) pyld_valid_d = 1'b1;
                            else                   drop_d       = 1'b1;
                        end
                        is_pad: begin
                            if (is_frame_end) begin
                                retrans_d = drop_q;
                                drop_d    = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                    // Realigned and expected-SOF beats all land on col 0, so they never clash with the above.
                    if (i_line_sof && !is_sof_pos) begin
                        frame_err_d = 1'b1;
                        miss_d      = '0;
                        drop_d      = 1'b1;
                    end else if (is_sof_pos) begin
                        if (i_line_sof) begin
                            miss_d = '0;
                        end else if (miss_q + 1'b1 == MISS_LIMIT) begin
                            state_d = HUNT;
                            miss_d  = '0;
                            drop_d  = 1'b0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= HUNT;
            miss_q       <= '0;
            drop_q       <= 1'b0;
            pyld_valid_q <= 1'b0;
            pyld_data_q  <= '0;
            frame_err_q  <= 1'b0;
            retrans_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_q       <= miss_d;
            drop_q       <= drop_d;
            pyld_valid_q <= pyld_valid_d;
            frame_err_q  <= frame_err_d;
            retrans_q    <= retrans_d;
            if (pyld_valid_d) pyld_data_q <= i_line_data;
        end
    end

`ifdef FRAME_DEMAP_OH_EXTRACT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            oh_valid_q <= 1'b0;
            oh_data_q  <= '0;
        end else begin
            oh_valid_q <= oh_valid_d;
            if (oh_valid_d) oh_data_q <= i_line_data;
        end
    end

    assign o_oh_valid = oh_valid_q;
    assign o_oh_data  = oh_data_q;
`endif

    assign o_pyld_valid  = pyld_valid_q;
    assign o_pyld_data   = pyld_data_q;
    assign o_in_frame    = (state_q == SYNC);
    assign o_frame_err   = frame_err_q;
    assign o_retrans_req = retrans_q;
endmodule

// File: tb/tb_frame_demap.sv
// Scoreboard bench for frame_demap: stimulus pushes expected payload/pulses, a monitor pops and compares.
module tb_frame_demap;
    import frame_demap_pkg::*;

    localparam int FRAME = NUM_ROWS * ROW_LEN;
    localparam int PYLD_PER_FRAME = NUM_ROWS * (PAD_COL - OH_COLS);

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [7:0]       i_line_data;
    logic             i_line_valid;
    logic             i_line_sof;
    logic             i_pyld_fifo_ready;
    logic [7:0]       o_pyld_data;
    logic             o_pyld_valid;
    logic [ROW_W-1:0] o_row_cnt;
    logic [COL_W-1:0] o_col_cnt;
    logic             o_in_frame;
    logic             o_frame_err;
    logic             o_retrans_req;
`ifdef FRAME_DEMAP_OH_EXTRACT_EN
    logic [7:0]       o_oh_data;
    logic             o_oh_valid;
`endif

    frame_demap dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_line_data       (i_line_data),
        .i_line_valid      (i_line_valid),
        .i_line_sof        (i_line_sof),
        .i_pyld_fifo_ready (i_pyld_fifo_ready),
        .o_pyld_data       (o_pyld_data),
        .o_pyld_valid      (o_pyld_valid),
        .o_row_cnt         (o_row_cnt),
        .o_col_cnt         (o_col_cnt),
        .o_in_frame        (o_in_frame),
        .o_frame_err       (o_frame_err),
        .o_retrans_req     (o_retrans_req)
`ifdef FRAME_DEMAP_OH_EXTRACT_EN
        ,
        .o_oh_data         (o_oh_data),
        .o_oh_valid        (o_oh_valid)
`endif
    );

    always #5 i_clk = ~i_clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         seq = 0;
    int         pyld_seen = 0;
    int         base;
    logic [7:0] exp_q[$];
    int         exp_retrans[$];
    int         exp_err[$];
    bit         model_drop = 1'b0;
    logic [7:0] man_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] dgen(input int s);
        return 8'((s * 37) ^ (s >>> 5));
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_pyld_valid) begin
                pyld_seen++;
                if (exp_q.size() == 0) check("pyld_unexpected", 32'(o_pyld_valid), 0);
                else check("pyld_data", 32'(o_pyld_data), 32'(exp_q.pop_front()));
            end
            if (o_retrans_req) begin
                if (exp_retrans.size() == 0) check("retrans_unexpected", 32'(o_retrans_req), 0);
                else check("retrans_cycle", cyc, exp_retrans.pop_front());
            end
            if (o_frame_err) begin
                if (exp_err.size() == 0) check("frame_err_unexpected", 32'(o_frame_err), 0);
                else check("frame_err_cycle", cyc, exp_err.pop_front());
            end
        end
    end

    // Drives n beats starting at (r0,c0). sof_en asserts SOF at every (0,0); inj forces SOF on the
    // first beat; fwd means the DUT is expected to be locked; ready drops at (drop_r,drop_c).
    task automatic run_beats(input int r0, input int c0, input int n, input bit sof_en, input bit inj,
                             input bit fwd, input int drop_r, input int drop_c, input bit gaps);
        int r = r0;
        int c = c0;
        int pc = 0;
        for (int i = 0; i < n; i++) begin
            bit         sof;
            bit         rdy;
            logic [7:0] d;
            if (gaps && i > 0 && $urandom_range(1, 0) == 1) begin
                i_line_valid = 1'b0;
                i_line_sof   = 1'($urandom_range(1, 0));
                i_line_data  = 8'($urandom_range(255, 0));
                @(posedge i_clk); #1;
                check("col_frozen_gap", 32'(o_col_cnt), pc);
            end
            sof = (inj && i == 0) || (sof_en && r == 0 && c == 0);
            rdy = !(r == drop_r && c == drop_c);
            d   = dgen(seq);
            seq++;
            i_line_valid      = 1'b1;
            i_line_sof        = sof;
            i_line_data       = d;
            i_pyld_fifo_ready = rdy;
            if (fwd && !sof && c >= OH_COLS && c < PAD_COL) begin
                if (rdy) exp_q.push_back(d);
                else     model_drop = 1'b1;
            end
            if (fwd && inj && i == 0) begin
                model_drop = 1'b1;
                exp_err.push_back(cyc + 1);
            end
            if (fwd && !sof && r == NUM_ROWS - 1 && c == PAD_COL) begin
                if (model_drop) exp_retrans.push_back(cyc + 1);
                model_drop = 1'b0;
            end
            @(posedge i_clk); #1;
            pc = sof ? 0 : c;
            c++;
            if (c == ROW_LEN) begin
                c = 0;
                r = (r + 1) % NUM_ROWS;
            end
        end
        i_line_valid      = 1'b0;
        i_line_sof        = 1'b0;
        i_pyld_fifo_ready = 1'b1;
    endtask

    initial begin
        i_rst             = 1'b1;
        i_line_valid      = 1'b0;
        i_line_sof        = 1'b0;
        i_line_data       = '0;
        i_pyld_fifo_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_pyld_valid", 32'(o_pyld_valid), 0);
        check("rst_in_frame", 32'(o_in_frame), 0);
        check("rst_row", 32'(o_row_cnt), 0);
        check("rst_col", 32'(o_col_cnt), 0);
        check("rst_frame_err", 32'(o_frame_err), 0);
        check("rst_retrans", 32'(o_retrans_req), 0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Hunting without SOF: everything discarded, counters stay 0.
        run_beats(0, 5, 20, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
        check("hunt_in_frame", 32'(o_in_frame), 0);
        check("hunt_col", 32'(o_col_cnt), 0);

        // Three clean frames.
        base = pyld_seen;
        run_beats(0, 0, 1, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
        check("lock_in_frame", 32'(o_in_frame), 1);
        check("lock_row", 32'(o_row_cnt), 0);
        check("lock_col", 32'(o_col_cnt), 0);
        run_beats(0, 1, 3 * FRAME - 1, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
        check("clean_pyld_count", pyld_seen - base, 3 * PYLD_PER_FRAME);
        check("clean_end_row", 32'(o_row_cnt), NUM_ROWS - 1);
        check("clean_end_col", 32'(o_col_cnt), PAD_COL);

        // One dropped byte at row 1, col 500.
        base = pyld_seen;
        run_beats(0, 0, FRAME, 1'b1, 1'b0, 1'b1, 1, 500, 1'b0);
        @(negedge i_clk); #1;
        check("drop_pyld_count", pyld_seen - base, PYLD_PER_FRAME - 1);
        check("drop_retrans_seen", exp_retrans.size(), 0);

        // Unexpected SOF at row 2, col 300, then the realigned frame.
        run_beats(0, 0, 2 * ROW_LEN + 300, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
        run_beats(2, 300, 1, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
        check("realign_row", 32'(o_row_cnt), 0);
        check("realign_col", 32'(o_col_cnt), 0);
        run_beats(0, 1, FRAME - 1, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
        @(negedge i_clk); #1;
        check("err_seen", exp_err.size(), 0);
        check("err_retrans_seen", exp_retrans.size(), 0);

        // Loss of frame after two missing SOFs.
        run_beats(0, 0, FRAME, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
        run_beats(0, 0, FRAME, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
        check("one_miss_in_frame", 32'(o_in_frame), 1);
        run_beats(0, 0, 1, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
        check("lof_in_frame", 32'(o_in_frame), 0);
        run_beats(0, 1, 2000, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
        check("lof_hold_in_frame", 32'(o_in_frame), 0);
        check("lof_hold_row", 32'(o_row_cnt), 0);
        check("lof_hold_col", 32'(o_col_cnt), 0);

        // Relock with random valid gaps.
        base = pyld_seen;
        run_beats(0, 0, FRAME, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1);
        check("gap_in_frame", 32'(o_in_frame), 1);
        check("gap_pyld_count", pyld_seen - base, PYLD_PER_FRAME);

        // Reset while a payload byte at row 1, col 700 is on the output.
        run_beats(0, 0, ROW_LEN + 700, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
        man_d = dgen(seq);
        seq++;
        i_line_valid = 1'b1;
        i_line_sof   = 1'b0;
        i_line_data  = man_d;
        @(posedge i_clk); #1;
        i_line_valid = 1'b0;
        check("inflight_valid", 32'(o_pyld_valid), 1);
        check("inflight_data", 32'(o_pyld_data), 32'(man_d));
        i_rst = 1'b1;
        #1;
        check("midrst_pyld_valid", 32'(o_pyld_valid), 0);
        check("midrst_pyld_data", 32'(o_pyld_data), 0);
        check("midrst_in_frame", 32'(o_in_frame), 0);
        check("midrst_row", 32'(o_row_cnt), 0);
        check("midrst_col", 32'(o_col_cnt), 0);
        model_drop = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        base = pyld_seen;
        run_beats(0, 0, FRAME, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
        check("relock_pyld_count", pyld_seen - base, PYLD_PER_FRAME);
        check("relock_row", 32'(o_row_cnt), NUM_ROWS - 1);
        check("relock_col", 32'(o_col_cnt), PAD_COL);

        repeat (3) @(negedge i_clk);
        #1;
        check("pyld_queue_drained", exp_q.size(), 0);
        check("retrans_queue_drained", exp_retrans.size(), 0);
        check("err_queue_drained", exp_err.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
